// File: rtl/timer_ctrl.sv
// timer_ctrl
//   Command-driven sequencer for a WIDTH-bit up-counter that runs either
//   one-shot or periodic up to a programmed limit. Commands arrive over a
//   valid/ready handshake; terminal count and illegal commands are reported
//   as single-cycle pulses. Every output comes straight from a register.
//
// Optional feature (compile-time macro):
//   TIMER_CTRL_PRESCALE_EN  when defined, the counter advances once every
//                           PRESCALE clocks via a prescaler that clears on
//                           START and freezes while paused. When undefined
//                           the counter may advance every clock and PRESCALE
//                           is only range-checked.
//
// Parameters:
//   WIDTH     counter / limit width
//   PRESCALE  clocks per counter tick (>= 1), prescaler builds only
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        asynchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  controller accepts commands (low only while in reset and
//              until the first clock edge after release)
//   cmd_op     00 START_ONE, 01 START_PER, 10 STOP, 11 PAUSE_TOGGLE
//   cmd_limit  terminal value, sampled on an accepted START
//   count      current counter value
//   busy       high in RUN or PAUSED
//   paused     high in PAUSED
//   tc         one-cycle terminal-count pulse
//   err        one-cycle illegal-command pulse

module timer_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             tc,
  output logic             err
);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("timer_ctrl: PRESCALE must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_START_ONE = 2'b00,
    OP_START_PER = 2'b01,
    OP_STOP      = 2'b10,
    OP_PAUSE     = 2'b11
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic             ready_q;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;
  logic             tc_q, tc_d;
  logic             err_q, err_d;

  op_e  op;
  logic accept;
  logic tick;

  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid & ready_q;

`ifdef TIMER_CTRL_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  assign tick = (pre_q == PRE_LAST);
`else
  assign tick = 1'b1;
`endif

  // Next-state logic. In RUN an accepted STOP or PAUSE_TOGGLE pre-empts the
  // tick on the same edge (count and prescaler do not advance); an accepted
  // START is illegal there, so it only raises err and the tick proceeds.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    tc_d       = 1'b0;
    err_d      = 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
    pre_d      = pre_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (op)
            OP_START_ONE, OP_START_PER: begin
              state_d    = RUN;
              limit_d    = cmd_limit;
              periodic_d = (op == OP_START_PER);
              count_d    = '0;
`ifdef TIMER_CTRL_PRESCALE_EN
              pre_d      = '0;
`endif
            end
            OP_STOP:  count_d = '0;
            OP_PAUSE: err_d   = 1'b1;
            default:  ;
          endcase
        end
      end

      RUN: begin
        if (accept && op == OP_STOP) begin
          state_d = IDLE;
          count_d = '0;
        end else if (accept && op == OP_PAUSE) begin
          state_d = PAUSED;
        end else begin
          if (accept) begin
            err_d = 1'b1;
          end
`ifdef TIMER_CTRL_PRESCALE_EN
          pre_d = tick ? '0 : pre_q + PW'(1);
`endif
          if (tick) begin
            if (count_q == limit_q) begin
              tc_d = 1'b1;
              if (periodic_q) begin
                count_d = '0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
      end

      PAUSED: begin
        if (accept) begin
          unique case (op)
            OP_PAUSE: state_d = RUN;
            OP_STOP: begin
              state_d = IDLE;
              count_d = '0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    busy_d   = (state_d == RUN) || (state_d == PAUSED);
    paused_d = (state_d == PAUSED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      limit_q    <= '0;
      periodic_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      paused_q   <= 1'b0;
      tc_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      ready_q    <= 1'b1;
      busy_q     <= busy_d;
      paused_q   <= paused_d;
      tc_q       <= tc_d;
      err_q      <= err_d;
    end
  end

`ifdef TIMER_CTRL_PRESCALE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`endif

  assign cmd_ready = ready_q;
  assign count     = count_q;
  assign busy      = busy_q;
  assign paused    = paused_q;
  assign tc        = tc_q;
  assign err       = err_q;

  a_count_le_limit : assert property (
    @(posedge clk) disable iff (rst) count_q <= limit_q
  );

  a_paused_implies_busy : assert property (
    @(posedge clk) disable iff (rst) paused_q |-> busy_q
  );

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl
//   Directed bench for timer_ctrl (WIDTH=8). Inputs change on the falling
//   edge; outputs are sampled on the falling edge (or just after an
//   asynchronous reset event). Builds with TIMER_CTRL_PRESCALE_EN defined
//   run the prescaler scenario in place of the per-clock timing scenarios.

module tb_timer_ctrl;

  localparam logic [1:0] START_ONE = 2'b00;
  localparam logic [1:0] START_PER = 2'b01;
  localparam logic [1:0] STOP      = 2'b10;
  localparam logic [1:0] PAUSE     = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_limit = 8'h00;
  logic [7:0] count;
  logic       busy;
  logic       paused;
  logic       tc;
  logic       err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  timer_ctrl #(
    .WIDTH    (8),
    .PRESCALE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_limit (cmd_limit),
    .count     (count),
    .busy      (busy),
    .paused    (paused),
    .tc        (tc),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [7:0] lim);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_limit = lim;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(3));
    cmd_limit = 8'($urandom_range(255));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input int c, input int b, input int p, input int t, input int e);
    check_eq({tag, ".count"},  32'(count),  32'(c));
    check_eq({tag, ".busy"},   32'(busy),   32'(b));
    check_eq({tag, ".paused"}, 32'(paused), 32'(p));
    check_eq({tag, ".tc"},     32'(tc),     32'(t));
    check_eq({tag, ".err"},    32'(err),    32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Power-on reset
    @(negedge clk);
    check_status("por", 0, 0, 0, 0, 0);
    check_eq("por.ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    #1 check_eq("rel.ready0", 32'(cmd_ready), 0);
    step();
    check_eq("rel.ready1", 32'(cmd_ready), 1);

    // Valid low: command ignored
    cmd_op = START_ONE;
    cmd_limit = 8'd3;
    step();
    check_status("novalid", 0, 0, 0, 0, 0);

    // PAUSE_TOGGLE in IDLE is illegal
    send(PAUSE, 8'd0);
    check_status("idle_pause", 0, 0, 0, 0, 1);
    step();
    check_status("idle_pause_n", 0, 0, 0, 0, 0);

`ifdef TIMER_CTRL_PRESCALE_EN
    // One tick every four clocks
    send(START_ONE, 8'd1);
    check_status("pre.c0", 0, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 4)       check_status("pre.lo", 0, 1, 0, 0, 0);
      else if (k < 8)  check_status("pre.hi", 1, 1, 0, 0, 0);
      else             check_status("pre.tc", 1, 0, 0, 1, 0);
    end
    step();
    check_status("pre.done", 1, 0, 0, 0, 0);
`else
    // One-shot, limit 5
    send(START_ONE, 8'd5);
    check_status("one.c0", 0, 1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check_status("one.run", k, 1, 0, 0, 0);
    end
    step();
    check_status("one.tc", 5, 0, 0, 1, 0);
    step();
    check_status("one.done", 5, 0, 0, 0, 0);

    // Periodic, limit 2
    send(START_PER, 8'd2);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      check_status("per", i % 3, 1, 0, (i > 0 && i % 3 == 0) ? 1 : 0, 0);
    end
    send(STOP, 8'd0);
    check_status("per.stop", 0, 0, 0, 0, 0);

    // Pause at count 2, hold, resume
    send(START_ONE, 8'd7);
    step();
    step();
    check_status("pz.pre", 2, 1, 0, 0, 0);
    send(PAUSE, 8'd0);
    check_status("pz.enter", 2, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_status("pz.hold", 2, 1, 1, 0, 0);
    end
    send(PAUSE, 8'd0);
    check_status("pz.resume", 2, 1, 0, 0, 0);
    for (int k = 3; k <= 7; k++) begin
      step();
      check_status("pz.run", k, 1, 0, 0, 0);
    end
    step();
    check_status("pz.tc", 7, 0, 0, 1, 0);

    // START while running: err, tick still advances, limit unchanged
    send(START_ONE, 8'd3);
    step();
    check_status("rs.c1", 1, 1, 0, 0, 0);
    send(START_ONE, 8'd9);
    check_status("rs.err", 2, 1, 0, 0, 1);
    step();
    check_status("rs.c3", 3, 1, 0, 0, 0);
    step();
    check_status("rs.tc", 3, 0, 0, 1, 0);

    // START in PAUSED is illegal
    send(START_PER, 8'd4);
    send(PAUSE, 8'd0);
    send(START_ONE, 8'd1);
    check_status("ps.err", 0, 1, 1, 0, 1);
    send(STOP, 8'd0);
    check_status("ps.stop", 0, 0, 0, 0, 0);

    // STOP on the terminal-tick edge wins, no tc
    send(START_ONE, 8'd2);
    step();
    step();
    check_status("st.c2", 2, 1, 0, 0, 0);
    send(STOP, 8'd0);
    check_status("st.stop", 0, 0, 0, 0, 0);
    step();
    check_status("st.after", 0, 0, 0, 0, 0);

    // Periodic limit 0: tc every tick, count stuck at 0
    send(START_PER, 8'd0);
    check_status("z.c0", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_status("z.tc", 0, 1, 0, 1, 0);
    end
    send(STOP, 8'd0);

    // One-shot limit 0: tc on first tick
    send(START_ONE, 8'd0);
    step();
    check_status("z1.tc", 0, 0, 0, 1, 0);

    // Full-range limit reaches all-ones without wrapping
    send(START_ONE, 8'd255);
    for (int k = 1; k <= 255; k++) step();
    check_status("max.ff", 255, 1, 0, 0, 0);
    step();
    check_status("max.tc", 255, 0, 0, 1, 0);

    // STOP in IDLE clears count, no err
    send(STOP, 8'd0);
    check_status("idle_stop", 0, 0, 0, 0, 0);

    // Asynchronous reset mid-run at count 3
    send(START_ONE, 8'd9);
    step();
    step();
    step();
    check_status("mr.c3", 3, 1, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_status("mr.rst", 0, 0, 0, 0, 0);
    check_eq("mr.ready0", 32'(cmd_ready), 0);
    step();
    rst = 1'b0;
    #1 check_eq("mr.ready_rel", 32'(cmd_ready), 0);
    step();
    check_eq("mr.ready1", 32'(cmd_ready), 1);
    check_status("mr.idle", 0, 0, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
